// File: rtl/pid_pkg.sv
// Shared types and constants for the PID compute stage: FSM states, default
// widths, gain field offsets within the packed gain word, and saturation limits.
package pid_pkg;

  localparam int unsigned DW_DEF     = 12;
  localparam int unsigned OW_DEF     = 17;
  localparam int unsigned ISHIFT_DEF = 4;

  localparam int unsigned GW     = 4;
  localparam int unsigned KP_LSB = 0;
  localparam int unsigned KI_LSB = 4;
  localparam int unsigned KD_LSB = 8;

  localparam int signed SAT_MAX = 65535;
  localparam int signed SAT_MIN = -65536;

  typedef enum logic [2:0] {
    IDLE,
    ERR,
    TERM_P,
    TERM_I,
    TERM_D,
    OUT
  } pid_state_e;

endpackage

// File: rtl/pid_sat.sv
// Generic signed saturator: clamps an IW-bit signed value into the OW-bit
// output range [SAT_MIN, SAT_MAX].
module pid_sat
  import pid_pkg::*;
#(
  parameter int unsigned IW = 24,
  parameter int unsigned OW = OW_DEF
) (
  input  logic signed [IW-1:0] d_i,
  output logic signed [OW-1:0] q_c
);

  localparam logic signed [IW-1:0] HI = IW'(SAT_MAX);
  localparam logic signed [IW-1:0] LO = IW'(SAT_MIN);

  always_comb begin
    q_c = OW'(d_i);
    if (d_i > HI) begin
      q_c = OW'(SAT_MAX);
    end else if (d_i < LO) begin
      q_c = OW'(SAT_MIN);
    end
  end

endmodule

// File: rtl/pid_engine.sv
// Multi-cycle PID stage with one shared multiplier sequenced over P, I and D.
// Optional integral anti-windup is enabled with `define PID_ANTIWINDUP_EN.
module pid_engine
  import pid_pkg::*;
#(
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned OW     = OW_DEF,
  parameter int unsigned ISHIFT = ISHIFT_DEF
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic                 start,
  input  logic [DW-1:0]        feedback,
  input  logic [DW-1:0]        target,
  input  logic [11:0]          para,
  output logic signed [OW-1:0] pid_out,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned EW  = DW + 1;
  localparam int unsigned DFW = DW + 2;
  localparam int unsigned SW  = OW + 1;
  localparam int unsigned MW  = OW;
  localparam int unsigned PW  = MW + GW + 1;
  localparam int unsigned AW  = 24;

  localparam logic signed [OW-1:0] SAT_HI = OW'(SAT_MAX);
  localparam logic signed [OW-1:0] SAT_LO = OW'(SAT_MIN);

  pid_state_e state_q, state_d;
  logic [DW-1:0]         fb_q, fb_d, tgt_q, tgt_d;
  logic [11:0]           para_q, para_d;
  logic signed [EW-1:0]  e_q, e_d, e_prev_q, e_prev_d;
  logic signed [DFW-1:0] d_q, d_d;
  logic signed [OW-1:0]  integ_q, integ_d;
  logic signed [AW-1:0]  acc_q, acc_d;
  logic signed [OW-1:0]  pid_out_q, pid_out_d;
  logic                  busy_q, busy_d, done_q, done_d;

  logic signed [EW-1:0]  e_c;
  logic signed [DFW-1:0] d_c;
  logic signed [SW-1:0]  integ_sum_c;
  logic signed [OW-1:0]  integ_sat_c, out_sat_c;
  logic                  hold_c;
  logic [GW-1:0]         gain_c;
  logic signed [MW-1:0]  opnd_c;
  logic signed [PW-1:0]  prod_c;
  logic signed [AW-1:0]  prod_ext_c, prod_sh_c;

  assign e_c         = $signed({1'b0, tgt_q}) - $signed({1'b0, fb_q});
  assign d_c         = DFW'(e_c) - DFW'(e_prev_q);
  assign integ_sum_c = SW'(integ_q) + SW'(e_c);

  // Freeze the integral while the output is pinned and the error pushes further into the rail.
`ifdef PID_ANTIWINDUP_EN
  assign hold_c = ((pid_out_q == SAT_HI) && !e_c[EW-1] && (e_c != '0)) ||
                  ((pid_out_q == SAT_LO) &&  e_c[EW-1]);
`else
  assign hold_c = 1'b0;
`endif

  pid_sat #(.IW(SW), .OW(OW)) u_int_sat (.d_i(integ_sum_c), .q_c(integ_sat_c));
  pid_sat #(.IW(AW), .OW(OW)) u_out_sat (.d_i(acc_q),       .q_c(out_sat_c));

  // Shared multiplier operand selection; gains are unsigned, data is signed.
  always_comb begin
    gain_c = '0;
    opnd_c = '0;
    case (state_q)
      TERM_P: begin gain_c = para_q[KP_LSB +: GW]; opnd_c = MW'(e_q);  end
      TERM_I: begin gain_c = para_q[KI_LSB +: GW]; opnd_c = integ_q;   end
      TERM_D: begin gain_c = para_q[KD_LSB +: GW]; opnd_c = MW'(d_q);  end
      default: ;
    endcase
  end

  assign prod_c     = PW'($signed({1'b0, gain_c})) * PW'(opnd_c);
  assign prod_ext_c = AW'(prod_c);
  assign prod_sh_c  = AW'(prod_c >>> ISHIFT);

  always_comb begin
    state_d   = state_q;
    fb_d      = fb_q;
    tgt_d     = tgt_q;
    para_d    = para_q;
    e_d       = e_q;
    e_prev_d  = e_prev_q;
    d_d       = d_q;
    integ_d   = integ_q;
    acc_d     = acc_q;
    pid_out_d = pid_out_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          fb_d    = feedback;
          tgt_d   = target;
          para_d  = para;
          state_d = ERR;
        end
      end
      ERR: begin
        e_d     = e_c;
        d_d     = d_c;
        integ_d = hold_c ? integ_q : integ_sat_c;
        state_d = TERM_P;
      end
      TERM_P: begin
        acc_d   = prod_ext_c;
        state_d = TERM_I;
      end
      TERM_I: begin
        acc_d   = acc_q + prod_sh_c;
        state_d = TERM_D;
      end
      TERM_D: begin
        acc_d   = acc_q + prod_ext_c;
        state_d = OUT;
      end
      OUT: begin
        pid_out_d = out_sat_c;
        e_prev_d  = e_q;
        done_d    = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      fb_q      <= '0;
      tgt_q     <= '0;
      para_q    <= '0;
      e_q       <= '0;
      e_prev_q  <= '0;
      d_q       <= '0;
      integ_q   <= '0;
      acc_q     <= '0;
      pid_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      fb_q      <= fb_d;
      tgt_q     <= tgt_d;
      para_q    <= para_d;
      e_q       <= e_d;
      e_prev_q  <= e_prev_d;
      d_q       <= d_d;
      integ_q   <= integ_d;
      acc_q     <= acc_d;
      pid_out_q <= pid_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign pid_out = pid_out_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pid_engine.sv
// Directed bench for pid_engine: latency/busy profile, integral accumulation,
// saturation, ignored start, back-to-back start and mid-computation reset.
module tb_pid_engine;

  logic               PCLK = 1'b0;
  logic               PRESET;
  logic               start;
  logic [11:0]        feedback, target, para;
  logic signed [16:0] pid_out;
  logic               busy, done;

  int tests = 0;
  int fails = 0;

  pid_engine dut (
    .PCLK(PCLK), .PRESET(PRESET), .start(start), .feedback(feedback),
    .target(target), .para(para), .pid_out(pid_out), .busy(busy), .done(done)
  );

  always #5 PCLK = ~PCLK;

  // Drives inputs and a one-cycle start; returns at the sample point of cycle 1.
  task automatic kick(input logic [11:0] t, input logic [11:0] fb, input logic [11:0] p);
    @(negedge PCLK);
    target = t; feedback = fb; para = p; start = 1'b1;
    @(negedge PCLK);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge PCLK);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic test_reset();
    PRESET = 1'b1; start = 1'b0; target = '0; feedback = '0; para = '0;
    repeat (2) @(negedge PCLK);
    tests++;
    if (pid_out !== 17'sd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: got pid_out=%0d busy=%b done=%b, expected 0 0 0", pid_out, busy, done);
    end
    PRESET = 1'b0;
    @(negedge PCLK);
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_idle: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_basic();
    kick(12'd1000, 12'd900, 12'h412);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge PCLK);
      tests++;
      if (busy !== (c >= 1 && c <= 5)) begin
        fails++;
        $display("FAIL basic_busy_c%0d: got %b expected %b", c, busy, (c >= 1 && c <= 5));
      end
      tests++;
      if (done !== (c == 6)) begin
        fails++;
        $display("FAIL basic_done_c%0d: got %b expected %b", c, done, (c == 6));
      end
      if (c == 5) begin
        tests++;
        if (pid_out !== 17'sd0) begin
          fails++;
          $display("FAIL basic_pre_update: got %0d expected 0", pid_out);
        end
      end
      if (c == 6) begin
        tests++;
        if (pid_out !== 17'sd606) begin
          fails++;
          $display("FAIL basic_pid_out: got %0d expected 606", pid_out);
        end
      end
    end
  endtask

  task automatic test_integral();
    kick(12'd1000, 12'd900, 12'h412);
    repeat (5) @(negedge PCLK);
    tests++;
    if (done !== 1'b1 || pid_out !== 17'sd212) begin
      fails++;
      $display("FAIL integral_pid_out: got done=%b pid_out=%0d expected 1 212", done, pid_out);
    end
    repeat (3) @(negedge PCLK);
    tests++;
    if (pid_out !== 17'sd212 || done !== 1'b0) begin
      fails++;
      $display("FAIL integral_hold: got done=%b pid_out=%0d expected 0 212", done, pid_out);
    end
  endtask

  task automatic test_pos_sat();
    kick(12'd4095, 12'd0, 12'hF0F);
    repeat (5) @(negedge PCLK);
    tests++;
    if (done !== 1'b1 || pid_out !== 17'h0FFFF) begin
      fails++;
      $display("FAIL pos_sat: got done=%b pid_out=%h expected 1 0ffff", done, pid_out);
    end
  endtask

  task automatic test_neg_sat();
    do_reset();
    kick(12'd0, 12'd4095, 12'hF0F);
    repeat (5) @(negedge PCLK);
    tests++;
    if (done !== 1'b1 || pid_out !== 17'h10000) begin
      fails++;
      $display("FAIL neg_sat: got done=%b pid_out=%h expected 1 10000", done, pid_out);
    end
  endtask

  task automatic test_ignore_start();
    int ndone = 0;
    do_reset();
    kick(12'd1000, 12'd900, 12'h412);
    for (int c = 1; c <= 12; c++) begin
      if (c > 1) @(negedge PCLK);
      if (c == 2) begin
        start = 1'b1; target = 12'd50; feedback = 12'd3000; para = 12'hFFF;
      end else begin
        start = 1'b0;
      end
      if (done) ndone++;
      if (c == 6) begin
        tests++;
        if (done !== 1'b1 || pid_out !== 17'sd606) begin
          fails++;
          $display("FAIL ignore_pid_out: got done=%b pid_out=%0d expected 1 606", done, pid_out);
        end
      end
    end
    tests++;
    if (ndone != 1) begin
      fails++;
      $display("FAIL ignore_done_count: got %0d expected 1", ndone);
    end
  endtask

  task automatic test_back_to_back();
    kick(12'd1000, 12'd900, 12'h412);
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) @(negedge PCLK);
      start = (c == 6);
      if (c == 6) begin
        tests++;
        if (done !== 1'b1 || pid_out !== 17'sd212) begin
          fails++;
          $display("FAIL b2b_first: got done=%b pid_out=%0d expected 1 212", done, pid_out);
        end
      end
      if (c == 7) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL b2b_accept: got busy=%b expected 1", busy);
        end
      end
      if (c == 12) begin
        tests++;
        if (done !== 1'b1 || pid_out !== 17'sd218) begin
          fails++;
          $display("FAIL b2b_second: got done=%b pid_out=%0d expected 1 218", done, pid_out);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int ndone = 0;
    kick(12'd1000, 12'd900, 12'h412);
    repeat (2) @(negedge PCLK);
    PRESET = 1'b1;
    #1;
    tests++;
    if (pid_out !== 17'sd0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_outputs: got pid_out=%0d busy=%b done=%b expected 0 0 0", pid_out, busy, done);
    end
    @(negedge PCLK);
    PRESET = 1'b0;
    repeat (6) begin
      @(negedge PCLK);
      if (done) ndone++;
    end
    tests++;
    if (ndone != 0) begin
      fails++;
      $display("FAIL reset_mid_no_done: got %0d done pulses expected 0", ndone);
    end
    kick(12'd1000, 12'd900, 12'h412);
    repeat (5) @(negedge PCLK);
    tests++;
    if (done !== 1'b1 || pid_out !== 17'sd606) begin
      fails++;
      $display("FAIL reset_mid_restart: got done=%b pid_out=%0d expected 1 606", done, pid_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_integral();
    test_pos_sat();
    test_neg_sat();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
